// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift register sequencer.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    CAPTURE,
    RESP
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_bitcnt.sv
// Loadable bit-index counter; 'last' flags the final shift of a command of length 'len'.
module shift_seq_bitcnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + CNT_W'(1);
    end
  end

  assign last = ((idx + CNT_W'(1)) == len);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a bidirectional SIPO shift register.
// Define SHIFT_SEQ_ABORT_EN to add the abort input and rsp_aborted response flag.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             cmd_clr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_rstn,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             rsp_aborted
`endif
);

  state_e           state;
  logic             dir_q;
  logic [CNT_W-1:0] len_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] len_clamped;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_inc;
  logic             last;
  logic             next_bit;
  logic             abort_hit;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign len_clamped = (cmd_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_len;
  assign idx_inc     = idx + CNT_W'(1);

  // Serial bit for the following shift cycle.
  always_comb begin
    next_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (idx_inc == CNT_W'(i)) next_bit = data_q[i];
    end
  end

  shift_seq_bitcnt #(
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk  (clk),
    .rstn (rstn),
    .load (cmd_valid && cmd_ready),
    .inc  ((state == SHIFT) && !last),
    .len  (len_q),
    .idx  (idx),
    .last (last)
  );

`ifdef SHIFT_SEQ_ABORT_EN
  logic aborted_q;

  assign abort_hit   = abort && ((state == CLEAR) || (state == SHIFT));
  assign rsp_aborted = aborted_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aborted_q <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      aborted_q <= 1'b0;
    end else if (abort_hit) begin
      aborted_q <= 1'b1;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      sr_d      <= 1'b0;
      sr_en     <= 1'b0;
      sr_dir    <= 1'b0;
      sr_rstn   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      sr_rstn <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q  <= cmd_dir;
            len_q  <= len_clamped;
            data_q <= cmd_data;
            if (cmd_clr) begin
              state   <= CLEAR;
              sr_rstn <= 1'b0;
            end else if (len_clamped != '0) begin
              state  <= SHIFT;
              sr_en  <= 1'b1;
              sr_d   <= cmd_data[0];
              sr_dir <= cmd_dir;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CLEAR: begin
          if (!abort_hit && (len_q != '0)) begin
            state  <= SHIFT;
            sr_en  <= 1'b1;
            sr_d   <= data_q[0];
            sr_dir <= dir_q;
          end else begin
            state <= CAPTURE;
          end
        end
        SHIFT: begin
          if (last || abort_hit) begin
            state <= CAPTURE;
            sr_en <= 1'b0;
            sr_d  <= 1'b0;
          end else begin
            sr_d <= next_bit;
          end
        end
        CAPTURE: begin
          rsp_data  <= sr_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shift register and response scoreboard.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_len = '0;
  logic          cmd_clr = 1'b0;
  logic [W-1:0]  cmd_data = '0;
  logic          sr_d, sr_en, sr_dir, sr_rstn;
  logic [W-1:0]  sr_q;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          busy;
  logic          pre_en = 1'b0;
  logic [W-1:0]  pre_val = '0;
`ifdef SHIFT_SEQ_ABORT_EN
  logic          abort = 1'b0;
  logic          rsp_aborted;
  logic          exp_aborted = 1'b0;
`endif

  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  shift_seq_ctrl #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .cmd_clr   (cmd_clr),
    .cmd_data  (cmd_data),
    .sr_d      (sr_d),
    .sr_en     (sr_en),
    .sr_dir    (sr_dir),
    .sr_rstn   (sr_rstn),
    .sr_q      (sr_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    .abort       (abort),
    .rsp_aborted (rsp_aborted)
`endif
  );

  // Behavioural shift register; pre_en lets the bench preload it.
  always_ff @(posedge clk) begin
    if (!sr_rstn)    sr_q <= '0;
    else if (pre_en) sr_q <= pre_val;
    else if (sr_en)  sr_q <= sr_dir ? {sr_d, sr_q[W-1:1]} : {sr_q[W-2:0], sr_d};
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] r, input logic dir,
                                         input logic [CW-1:0] len, input logic clr,
                                         input logic [W-1:0] data);
    int n;
    n = (int'(len) > W) ? W : int'(len);
    if (clr) r = '0;
    for (int i = 0; i < n; i++) r = dir ? {data[i], r[W-1:1]} : {r[W-2:0], data[i]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [W-1:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en  = 1'b0;
  endtask

  // Drives one command; returns at the accept edge E0 plus 1.
  task automatic send(input string tag, input logic dir, input logic [CW-1:0] len,
                      input logic clr, input logic [W-1:0] data);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_len   = len;
    cmd_clr   = clr;
    cmd_data  = data;
    exp_q.push_back(model(sr_q, dir, len, clr, data));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_dir   = ~dir;
    cmd_len   = 3'd1;
    cmd_clr   = ~clr;
    cmd_data  = ~data;
    check({tag, "_busy"}, 32'(busy), 1);
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat, input int exp_en, input int exp_clr);
    int n;
    int en_cnt;
    int clr_cnt;
    n = 0;
    en_cnt = 0;
    clr_cnt = 0;
    while (!rsp_valid && n < 40) begin
      en_cnt  += int'(sr_en);
      clr_cnt += int'(!sr_rstn);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'(exp_en));
    check({tag, "_clr_cycles"}, 32'(clr_cnt), 32'(exp_clr));
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
    end else begin
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_q.pop_front()));
    end
`ifdef SHIFT_SEQ_ABORT_EN
    check({tag, "_rsp_aborted"}, 32'(rsp_aborted), 32'(exp_aborted));
`endif
  endtask

  // Holds rsp_ready low for 'hold' cycles, then completes the handshake.
  task automatic finish_rsp(input string tag, input int hold);
    logic [W-1:0] snap;
    snap = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(rsp_valid), 1);
      check({tag, "_hold_data"}, 32'(rsp_data), 32'(snap));
      check({tag, "_hold_ready"}, 32'(cmd_ready), 0);
      check({tag, "_hold_en"}, 32'(sr_en), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(rsp_valid), 0);
    check({tag, "_post_ready"}, 32'(cmd_ready), 1);
    check({tag, "_post_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_sr_en", 32'(sr_en), 0);
    check("rst_sr_d", 32'(sr_d), 0);
    check("rst_sr_dir", 32'(sr_dir), 0);
    check("rst_sr_rstn", 32'(sr_rstn), 0);
    check("rst_reg_cleared", 32'(sr_q), 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_sr_rstn_release", 32'(sr_rstn), 1);

    send("right_clr", DIR_RIGHT, 3'd4, 1'b1, 4'b0001);
    wait_rsp("right_clr", 6, 4, 1);
    check("right_clr_sr_dir", 32'(sr_dir), 1);
    finish_rsp("right_clr", 0);

    send("left_clr", DIR_LEFT, 3'd4, 1'b1, 4'b0001);
    wait_rsp("left_clr", 6, 4, 1);
    check("left_clr_sr_dir", 32'(sr_dir), 0);
    finish_rsp("left_clr", 0);

    preload(4'b0000);
    send("left_noclr", DIR_LEFT, 3'd4, 1'b0, 4'b0001);
    wait_rsp("left_noclr", 5, 4, 0);
    finish_rsp("left_noclr", 0);

    preload(4'b1111);
    send("partial", DIR_LEFT, 3'd2, 1'b0, 4'b0000);
    wait_rsp("partial", 3, 2, 0);
    finish_rsp("partial", 0);

    preload(4'b1010);
    send("len0", DIR_RIGHT, 3'd0, 1'b0, 4'b0110);
    wait_rsp("len0", 1, 0, 0);
    finish_rsp("len0", 0);

    send("len0_clr", DIR_LEFT, 3'd0, 1'b1, 4'b1111);
    wait_rsp("len0_clr", 2, 0, 1);
    finish_rsp("len0_clr", 0);

    preload(4'b0110);
    send("clamp", DIR_RIGHT, 3'd7, 1'b0, 4'b1011);
    wait_rsp("clamp", 5, 4, 0);
    finish_rsp("clamp", 0);

    // Backpressure with a second command pending during RESP.
    preload(4'b1001);
    send("bp", DIR_LEFT, 3'd3, 1'b0, 4'b0101);
    wait_rsp("bp", 4, 3, 0);
    cmd_valid = 1'b1;
    cmd_dir   = DIR_RIGHT;
    cmd_len   = 3'd2;
    cmd_clr   = 1'b0;
    cmd_data  = 4'b0011;
    finish_rsp("bp", 5);
    send("pending", DIR_RIGHT, 3'd2, 1'b0, 4'b0011);
    wait_rsp("pending", 3, 2, 0);
    finish_rsp("pending", 0);

    // Reset in the middle of a shift sequence.
    preload(4'b0000);
    send("midrst", DIR_LEFT, 3'd4, 1'b0, 4'b1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_two_bits", 32'(sr_q), 32'(4'b0011));
    rstn = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_sr_en", 32'(sr_en), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_cmd_ready", 32'(cmd_ready), 1);
    check("midrst_sr_rstn", 32'(sr_rstn), 0);
    @(posedge clk); #1;
    check("midrst_reg_cleared", 32'(sr_q), 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    send("after_rst", DIR_RIGHT, 3'd4, 1'b1, 4'b1001);
    wait_rsp("after_rst", 6, 4, 1);
    finish_rsp("after_rst", 0);

`ifdef SHIFT_SEQ_ABORT_EN
    preload(4'b0000);
    send("abort", DIR_LEFT, 3'd4, 1'b0, 4'b0011);
    void'(exp_q.pop_back());
    exp_q.push_back(model(4'b0000, DIR_LEFT, 3'd2, 1'b0, 4'b0011));
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_aborted = 1'b1;
    wait_rsp("abort", 1, 0, 0);
    finish_rsp("abort", 0);
    exp_aborted = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
